// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, register indices, ALU operation and
// control-select enums shared by the single-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5
    } alu_op_e;

    // Register write-back source
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    // Next-PC source
    typedef enum logic [2:0] {
        PC_SEQ  = 3'd0,
        PC_BEQ  = 3'd1,
        PC_BNE  = 3'd2,
        PC_JUMP = 3'd3,
        PC_REG  = 3'd4
    } pc_sel_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational ALU; zero flag feeds the beq/bne decision.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    // operation select; arithmetic wraps modulo 2^32, slt compares signed
    always_comb begin
        result_o = 32'h0000_0000;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            ALU_SLL: result_o = b_i << shamt_i;
            default: result_o = 32'h0000_0000;
        endcase
        zero_o = (result_o == 32'h0000_0000);
    end

endmodule

// File: rtl/mips_core_mem.sv
// State-holding units of mips_core: program counter, instruction ROM,
// register file and big-endian byte-addressed data memory. Array names are
// kept stable so benches can reach contents hierarchically.
module mips_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_i,
    output logic [31:0] OUT
);

    // program counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            OUT <= 32'h0000_0000;
        end else begin
            OUT <= next_i;
        end
    end

endmodule

module mips_imem #(
    parameter int WORDS = 256
) (
    input  logic [29:0] word_addr_i,
    output logic [31:0] instr_o
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // contents are preloaded externally through the InstructionMemory array
    logic [31:0]   InstructionMemory [WORDS];
    logic [AW-1:0] idx_s;

    // word-indexed fetch, wrapping at the memory depth
    always_comb begin
        idx_s   = AW'(word_addr_i % 30'(WORDS));
        instr_o = InstructionMemory[idx_s];
    end

endmodule

module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] Registers [32];

    // single write port; reset clears every entry, writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                Registers[i] <= 32'h0000_0000;
            end
        end else if (we_i && (wa_i != REG_ZERO)) begin
            Registers[wa_i] <= wd_i;
        end
    end

    // two combinational read ports with $0 hard-wired to zero
    always_comb begin
        rd1_o = (ra1_i == REG_ZERO) ? 32'h0000_0000 : Registers[ra1_i];
        rd2_o = (ra2_i == REG_ZERO) ? 32'h0000_0000 : Registers[ra2_i];
    end

endmodule

// BYTES is expected to be a power of two, at least 8.
module mips_dmem #(
    parameter int BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    localparam int AW = $clog2(BYTES);

    logic [7:0]    DataMemory [BYTES];
    logic [AW-1:0] base_s;

    // word-aligned base address (low two bits dropped) and big-endian read
    always_comb begin
        base_s      = AW'(addr_i % 32'(BYTES));
        base_s[1:0] = 2'b00;
        rdata_o     = {DataMemory[base_s],            DataMemory[base_s | AW'(1)],
                       DataMemory[base_s | AW'(2)],   DataMemory[base_s | AW'(3)]};
    end

    // big-endian word store at the edge; no store while reset is asserted
    always_ff @(posedge clk) begin
        if (we_i && !rst) begin
            DataMemory[base_s]          <= wdata_i[31:24];
            DataMemory[base_s | AW'(1)] <= wdata_i[23:16];
            DataMemory[base_s | AW'(2)] <= wdata_i[15:8];
            DataMemory[base_s | AW'(3)] <= wdata_i[7:0];
        end
    end

endmodule

// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS subset (add/sub/and/or/slt/sll, addi/andi/ori,
// lw/sw, beq/bne, j). Defining MIPS_CORE_JAL_EN adds jal and jr; otherwise
// both decode as NOPs like any other unlisted encoding.
module mips_core
    import mips_pkg::*;
#(
    parameter int IM_WORDS = 256,
    parameter int DM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc
);

    logic [31:0] pc_q, pc_d, pc_plus4_s, instr_s;
    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s, wa_s;
    logic [15:0] imm_s;
    logic [25:0] target_s;
    logic [31:0] simm_s, rs_data_s, rt_data_s, alu_b_s, alu_res_s;
    logic [31:0] dm_rdata_s, wd_s, br_target_s, jump_target_s;
    logic        alu_zero_s, reg_we_s, mem_we_s;
    alu_op_e     alu_op_s;
    wb_sel_e     wb_sel_s;
    pc_sel_e     pc_sel_s;

    assign pc            = pc_q;
    assign opcode_s      = instr_s[31:26];
    assign rs_s          = instr_s[25:21];
    assign rt_s          = instr_s[20:16];
    assign rd_s          = instr_s[15:11];
    assign shamt_s       = instr_s[10:6];
    assign funct_s       = instr_s[5:0];
    assign imm_s         = instr_s[15:0];
    assign target_s      = instr_s[25:0];
    assign simm_s        = sign_ext16(imm_s);
    assign pc_plus4_s    = pc_q + 32'd4;
    assign br_target_s   = pc_plus4_s + {simm_s[29:0], 2'b00};
    assign jump_target_s = {pc_plus4_s[31:28], target_s, 2'b00};

    mips_pc ProgCounter (.clk(clk), .rst(rst), .next_i(pc_d), .OUT(pc_q));

    mips_imem #(.WORDS(IM_WORDS)) IM (.word_addr_i(pc_q[31:2]), .instr_o(instr_s));

    mips_regfile RF (
        .clk(clk), .rst(rst),
        .ra1_i(rs_s), .ra2_i(rt_s), .rd1_o(rs_data_s), .rd2_o(rt_data_s),
        .we_i(reg_we_s), .wa_i(wa_s), .wd_i(wd_s)
    );

    mips_alu u_alu (
        .a_i(rs_data_s), .b_i(alu_b_s), .op_i(alu_op_s), .shamt_i(shamt_s),
        .result_o(alu_res_s), .zero_o(alu_zero_s)
    );

    mips_dmem #(.BYTES(DM_BYTES)) DM (
        .clk(clk), .rst(rst), .addr_i(alu_res_s), .we_i(mem_we_s),
        .wdata_i(rt_data_s), .rdata_o(dm_rdata_s)
    );

    // instruction decode; anything not matched falls through as a NOP
    always_comb begin
        alu_op_s = ALU_ADD;
        alu_b_s  = rt_data_s;
        reg_we_s = 1'b0;
        wa_s     = rd_s;
        wb_sel_s = WB_ALU;
        mem_we_s = 1'b0;
        pc_sel_s = PC_SEQ;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD: begin alu_op_s = ALU_ADD; reg_we_s = 1'b1; end
                    FN_SUB: begin alu_op_s = ALU_SUB; reg_we_s = 1'b1; end
                    FN_AND: begin alu_op_s = ALU_AND; reg_we_s = 1'b1; end
                    FN_OR:  begin alu_op_s = ALU_OR;  reg_we_s = 1'b1; end
                    FN_SLT: begin alu_op_s = ALU_SLT; reg_we_s = 1'b1; end
                    FN_SLL: begin alu_op_s = ALU_SLL; reg_we_s = 1'b1; end
`ifdef MIPS_CORE_JAL_EN
                    FN_JR:  pc_sel_s = PC_REG;
`endif
                    default: reg_we_s = 1'b0;
                endcase
            end
            OP_ADDI: begin alu_b_s = simm_s; reg_we_s = 1'b1; wa_s = rt_s; end
            OP_ANDI: begin
                alu_b_s = {16'h0000, imm_s}; alu_op_s = ALU_AND; reg_we_s = 1'b1; wa_s = rt_s;
            end
            OP_ORI: begin
                alu_b_s = {16'h0000, imm_s}; alu_op_s = ALU_OR; reg_we_s = 1'b1; wa_s = rt_s;
            end
            OP_LW: begin
                alu_b_s = simm_s; reg_we_s = 1'b1; wa_s = rt_s; wb_sel_s = WB_MEM;
            end
            OP_SW:  begin alu_b_s = simm_s; mem_we_s = 1'b1; end
            OP_BEQ: begin alu_op_s = ALU_SUB; pc_sel_s = PC_BEQ; end
            OP_BNE: begin alu_op_s = ALU_SUB; pc_sel_s = PC_BNE; end
            OP_J:   pc_sel_s = PC_JUMP;
`ifdef MIPS_CORE_JAL_EN
            OP_JAL: begin
                pc_sel_s = PC_JUMP; reg_we_s = 1'b1; wa_s = REG_RA; wb_sel_s = WB_LINK;
            end
`endif
            default: pc_sel_s = PC_SEQ;
        endcase
    end

    // next-PC selection; branches resolve on the ALU zero flag
    always_comb begin
        pc_d = pc_plus4_s;
        case (pc_sel_s)
            PC_SEQ:  pc_d = pc_plus4_s;
            PC_BEQ:  pc_d = alu_zero_s ? br_target_s : pc_plus4_s;
            PC_BNE:  pc_d = alu_zero_s ? pc_plus4_s : br_target_s;
            PC_JUMP: pc_d = jump_target_s;
            PC_REG:  pc_d = rs_data_s;
            default: pc_d = pc_plus4_s;
        endcase
    end

    // register write-back data
    always_comb begin
        wd_s = alu_res_s;
        case (wb_sel_s)
            WB_ALU:  wd_s = alu_res_s;
            WB_MEM:  wd_s = dm_rdata_s;
            WB_LINK: wd_s = pc_plus4_s;
            default: wd_s = alu_res_s;
        endcase
    end

endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core: directed and random programs run on mips_core and on an
// instruction-level reference model kept in the bench.
module tb_mips_core;

    localparam int IMW = 256;
    localparam int DMB = 1024;
`ifdef MIPS_CORE_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] prog  [IMW];
    logic [31:0] m_pc;
    logic [31:0] m_reg [32];
    logic [7:0]  m_dm  [DMB];

    mips_core #(.IM_WORDS(IMW), .DM_BYTES(DMB)) dut (.clk(clk), .rst(rst), .pc(pc));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic logic [31:0] dut_dm_word(input int a);
        return {dut.DM.DataMemory[a], dut.DM.DataMemory[a+1],
                dut.DM.DataMemory[a+2], dut.DM.DataMemory[a+3]};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 15))
            0:  return enc_r(6'h20, rs, rt, rd, 5'd0);
            1:  return enc_r(6'h22, rs, rt, rd, 5'd0);
            2:  return enc_r(6'h24, rs, rt, rd, 5'd0);
            3:  return enc_r(6'h25, rs, rt, rd, 5'd0);
            4:  return enc_r(6'h2A, rs, rt, rd, 5'd0);
            5:  return enc_r(6'h00, rs, rt, rd, 5'($urandom_range(0, 31)));
            6:  return enc_i(6'h08, rs, rt, imm);
            7:  return enc_i(6'h0C, rs, rt, imm);
            8:  return enc_i(6'h0D, rs, rt, imm);
            9:  return enc_i(6'h23, rs, rt, imm);
            10: return enc_i(6'h2B, rs, rt, imm);
            11: return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 6) - 3));
            12: return enc_i(6'h05, rs, rt, 16'($urandom_range(0, 6) - 3));
            13: return enc_j(6'h02, 26'($urandom_range(0, IMW - 1)));
            14: return ($urandom_range(0, 1) == 0) ? enc_j(6'h03, 26'($urandom_range(0, IMW - 1)))
                                                   : enc_r(6'h08, rs, 5'd0, 5'd0, 5'd0);
            default: return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)}
                                                        : enc_r(6'h21, rs, rt, rd, 5'd0);
        endcase
    endfunction

    task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    endtask

    // Executes one instruction of the ISA on the model state
    task automatic model_step();
        logic [31:0] ins, a, b, simm, p4, nxt;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        int          ea;
        ins  = prog[m_pc[9:2]];
        op   = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd   = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
        a    = m_reg[rs];
        b    = m_reg[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        p4   = m_pc + 32'd4;
        nxt  = p4;
        ea   = int'((a + simm) % 32'(DMB)) & ~3;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: m_wr(rd, a + b);
                    6'h22: m_wr(rd, a - b);
                    6'h24: m_wr(rd, a & b);
                    6'h25: m_wr(rd, a | b);
                    6'h2A: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    6'h00: m_wr(rd, b << sh);
                    6'h08: if (JAL_EN) nxt = a;
                    default: ;
                endcase
            end
            6'h08: m_wr(rt, a + simm);
            6'h0C: m_wr(rt, a & {16'h0, ins[15:0]});
            6'h0D: m_wr(rt, a | {16'h0, ins[15:0]});
            6'h23: m_wr(rt, {m_dm[ea], m_dm[ea+1], m_dm[ea+2], m_dm[ea+3]});
            6'h2B: begin
                m_dm[ea] = b[31:24]; m_dm[ea+1] = b[23:16];
                m_dm[ea+2] = b[15:8]; m_dm[ea+3] = b[7:0];
            end
            6'h04: if (a == b) nxt = p4 + (simm << 2);
            6'h05: if (a != b) nxt = p4 + (simm << 2);
            6'h02: nxt = {p4[31:28], ins[25:0], 2'b00};
            6'h03: if (JAL_EN) begin
                m_wr(5'd31, p4);
                nxt = {p4[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < IMW; i++) prog[i] = 32'h0;
    endtask

    // Loads the program while held in reset, then releases reset
    task automatic start_prog();
        rst = 1'b1;
        for (int i = 0; i < IMW; i++) dut.IM.InstructionMemory[i] = prog[i];
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_eq("rst_pc", pc, 32'h0);
    endtask

    task automatic run_steps(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk); #1;
            check_eq($sformatf("%s_pc%0d", tag, k), pc, m_pc);
        end
    endtask

    task automatic compare_state(input string tag);
        for (int i = 0; i < 32; i++)
            check_eq($sformatf("%s_r%0d", tag, i), dut.RF.Registers[i], m_reg[i]);
        for (int w = 0; w < DMB; w += 4)
            check_eq($sformatf("%s_dm%0d", tag, w), dut_dm_word(w),
                     {m_dm[w], m_dm[w+1], m_dm[w+2], m_dm[w+3]});
    endtask

    initial begin
        // clear all of data memory with a store loop
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd1020);
        prog[1] = enc_i(6'h2B, 5'd8, 5'd0, 16'd0);
        prog[2] = enc_i(6'h08, 5'd8, 5'd8, 16'hFFFC);
        prog[3] = enc_i(6'h05, 5'd8, 5'd0, 16'hFFFD);
        prog[4] = enc_i(6'h2B, 5'd0, 5'd0, 16'd0);
        prog[5] = enc_j(6'h02, 26'd5);
        start_prog();
        run_steps(780, "clr");
        compare_state("clr");

        // seed DM words 0/1 with 0x11111111 / 0x22222222
        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd8, 16'h1111);
        prog[1] = enc_r(6'h00, 5'd0, 5'd8, 5'd8, 5'd16);
        prog[2] = enc_i(6'h0D, 5'd8, 5'd8, 16'h1111);
        prog[3] = enc_i(6'h0D, 5'd0, 5'd9, 16'h2222);
        prog[4] = enc_r(6'h00, 5'd0, 5'd9, 5'd9, 5'd16);
        prog[5] = enc_i(6'h0D, 5'd9, 5'd9, 16'h2222);
        prog[6] = enc_i(6'h2B, 5'd0, 5'd8, 16'd0);
        prog[7] = enc_i(6'h2B, 5'd0, 5'd9, 16'd4);
        prog[8] = enc_j(6'h02, 26'd8);
        start_prog();
        run_steps(8, "prep");

        // swap through registers
        clear_prog();
        prog[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
        prog[1] = enc_i(6'h23, 5'd0, 5'd9, 16'd4);
        prog[2] = enc_i(6'h2B, 5'd0, 5'd9, 16'd0);
        prog[3] = enc_i(6'h2B, 5'd0, 5'd8, 16'd4);
        start_prog();
        check_eq("keep_w0", dut_dm_word(0), 32'h11111111);
        check_eq("keep_w1", dut_dm_word(4), 32'h22222222);
        run_steps(4, "swap");
        check_eq("swap_w0", dut_dm_word(0), 32'h22222222);
        check_eq("swap_w1", dut_dm_word(4), 32'h11111111);
        check_eq("swap_t0", dut.RF.Registers[8], 32'h11111111);
        check_eq("swap_t1", dut.RF.Registers[9], 32'h22222222);
        check_eq("swap_pc", pc, 32'h10);

        // arithmetic, interrupted by a reset after three instructions
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
        prog[1] = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
        prog[2] = enc_r(6'h20, 5'd8, 5'd9, 5'd10, 5'd0);
        prog[3] = enc_r(6'h2A, 5'd9, 5'd8, 5'd11, 5'd0);
        start_prog();
        run_steps(3, "arith_a");
        check_eq("pre_rst_t2", dut.RF.Registers[10], 32'h2);
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_eq("midrst_pc", pc, 32'h0);
        for (int i = 0; i < 32; i++)
            check_eq($sformatf("midrst_r%0d", i), dut.RF.Registers[i], 32'h0);
        check_eq("midrst_w0", dut_dm_word(0), 32'h22222222);
        check_eq("midrst_w1", dut_dm_word(4), 32'h11111111);
        rst = 1'b0;
        run_steps(4, "arith_b");
        check_eq("arith_t2", dut.RF.Registers[10], 32'h00000002);
        check_eq("arith_t3", dut.RF.Registers[11], 32'h00000001);

        // branches taken / not taken from pc 0
        clear_prog();
        prog[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        start_prog();
        run_steps(1, "beq");
        check_eq("beq_pc", pc, 32'h0C);
        clear_prog();
        prog[0] = enc_i(6'h05, 5'd0, 5'd0, 16'd2);
        start_prog();
        run_steps(1, "bne");
        check_eq("bne_pc", pc, 32'h04);

        // register 0 ignores writes
        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd8, 16'd3);
        prog[1] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        prog[2] = enc_r(6'h20, 5'd0, 5'd8, 5'd9, 5'd0);
        start_prog();
        run_steps(3, "zero");
        check_eq("zero_r0", dut.RF.Registers[0], 32'h0);
        check_eq("zero_r9", dut.RF.Registers[9], 32'h3);

        // big-endian store, then load of the same word next cycle
        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd8, 16'hAABB);
        prog[1] = enc_r(6'h00, 5'd0, 5'd8, 5'd8, 5'd16);
        prog[2] = enc_i(6'h0D, 5'd8, 5'd8, 16'hCCDD);
        prog[3] = enc_i(6'h2B, 5'd0, 5'd8, 16'd8);
        prog[4] = enc_i(6'h23, 5'd0, 5'd9, 16'd8);
        start_prog();
        run_steps(5, "be");
        check_eq("be_b8",  {24'h0, dut.DM.DataMemory[8]},  32'hAA);
        check_eq("be_b9",  {24'h0, dut.DM.DataMemory[9]},  32'hBB);
        check_eq("be_b10", {24'h0, dut.DM.DataMemory[10]}, 32'hCC);
        check_eq("be_b11", {24'h0, dut.DM.DataMemory[11]}, 32'hDD);
        check_eq("be_lw",  dut.RF.Registers[9], 32'hAABBCCDD);

        // random programs against the model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < IMW; i++) prog[i] = rand_instr();
            start_prog();
            run_steps(300, $sformatf("rnd%0d", r));
            compare_state($sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_core.md
MIPS_CORE -- requirements
Module: mips_core

Interface
REQ-001 SHALL have parameter IM_WORDS, default 256, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter DM_BYTES, default 1024, meaning data-memory size in bytes.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port pc, output, 32 bits: current program-counter value.

Function
REQ-006 SHALL be a single-cycle core: one instruction fetched, executed and retired per rising clk edge.
REQ-007 SHALL fetch from the word-indexed instruction memory at pc[31:2] modulo IM_WORDS; memory loadable by $readmemh (hex, one word per line).
REQ-008 SHALL hold 32 x 32-bit registers with two combinational read ports and one write port written at the clock edge; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-009 SHALL implement R-type (opcode 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00 (shamt); rd written.
REQ-010 SHALL implement I-type: addi 0x08 (sign-extended), andi 0x0C and ori 0x0D (zero-extended), lw 0x23, sw 0x2B, beq 0x04, bne 0x05; rt written where applicable.
REQ-011 SHALL implement j 0x02: next pc = {pc+4[31:28], target, 2'b00}.
REQ-012 SHALL compute branch target pc+4+(sign-extended imm << 2); otherwise next pc = pc+4.
REQ-013 SHALL wrap arithmetic modulo 2^32; no overflow trap.
REQ-014 SHALL treat any unlisted opcode/funct as a NOP (pc+4, no register or memory write).
REQ-015 SHALL store data memory as DM_BYTES bytes, big-endian: byte at address A is word bits [31:24]; addresses taken modulo DM_BYTES, low two bits of lw/sw address ignored (word aligned).
REQ-016 SHALL read lw data combinationally and write the register at the edge; sw SHALL write all four bytes at the edge.
REQ-017 SHALL, for lw and sw to the same word in consecutive cycles, return the newly stored value to the lw.

Reset
REQ-018 SHALL, while rst is high at a rising edge, set pc to 0x00000000 and clear all 32 registers; no memory write occurs that cycle.
REQ-019 SHALL leave instruction and data memory contents unchanged by reset, including reset asserted mid-program.
REQ-020 SHALL resume fetching at address 0 on the first edge after rst deasserts.

Configuration
REQ-021 SHALL, when macro MIPS_CORE_JAL_EN is defined, additionally implement jal 0x03 (writes pc+4 to register 31, jumps as j) and jr (R-type funct 0x08, next pc = rs).
REQ-022 SHALL, without MIPS_CORE_JAL_EN, treat jal and jr as NOPs per REQ-014.

Structure
REQ-023 SHALL place opcode and funct constants, ALU-operation enum and register-index constants in shared package mips_pkg.
REQ-024 SHALL use sub-module mips_alu (operands, op, shamt -> result, zero); the PC register, instruction memory, register file and data memory SHALL be instances named ProgCounter (field OUT), IM (array InstructionMemory), RF (array Registers) and DM (array DataMemory) so benches can reach them hierarchically.

Verification
REQ-025 Swap: DM words 0/1 = 0x11111111/0x22222222; program lw $t0,0($0); lw $t1,4($0); sw $t1,0($0); sw $t0,4($0) -> after 4 edges DM word0 = 0x22222222, word1 = 0x11111111, $t0 = 0x11111111, $t1 = 0x22222222, pc = 0x10.
REQ-026 Arithmetic: addi $t0,$0,5; addi $t1,$0,-3; add $t2,$t0,$t1; slt $t3,$t1,$t0 -> $t2 = 0x00000002, $t3 = 1.
REQ-027 Branch: beq $0,$0,+2 at pc 0 -> next pc = 0x0C; bne $0,$0,+2 -> next pc = 0x04.
REQ-028 Zero register: addi $0,$0,7 -> $0 reads 0x00000000.
REQ-029 Reset mid-run: assert rst after 3 instructions -> pc = 0 and all registers 0 after one edge; DM contents retained.
REQ-030 Big-endian: sw of 0xAABBCCDD to address 8 -> bytes 8..11 = AA, BB, CC, DD.
